// File: rtl/video_timing_pkg.sv
// Shared 720p60 timing constants, counter widths and FSM state encoding
// for the video timing generator.
package video_timing_pkg;
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int LOCK_STABLE = 1024;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef logic [0:0] state_t;
  localparam state_t WAIT_LOCK = 1'b0;
  localparam state_t RUN       = 1'b1;
endpackage

// File: rtl/video_timing_gen_lock_qualifier.sv
// Synchronizes the raw PLL lock and qualifies it: lock_ok once lock_s has
// been high for LOCK_N consecutive cycles.
module lock_qualifier #(
  parameter int LOCK_N = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_s,
  output logic lock_ok
);
  localparam int CW = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_N - 1);

  logic          sync1;
  logic [CW-1:0] cnt;

  // Counter saturates so lock_ok stays high for as long as lock holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
      if (!lock_s)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  assign lock_ok = lock_s && (cnt == CNT_MAX);
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: lock-gated h/v counters, registered sync/de
// decode and one-ahead line-fetch requests for the framebuffer reader.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP,
  parameter int LOCK_N  = LOCK_STABLE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pll_lock,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           line_req,
  output logic [Y_W-1:0] line_req_y,
  input  logic           line_ack,
  output logic           underrun,
  output logic           running
);
  localparam int HT = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int VT = V_ACT + V_FRONT + V_PULSE + V_BACK;

  localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACT);
  localparam logic [X_W-1:0] H_LAST   = X_W'(HT - 1);
  localparam logic [X_W-1:0] HS_BEG   = X_W'(H_ACT + H_FRONT);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACT + H_FRONT + H_PULSE);
  localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACT);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(VT - 1);
  localparam logic [Y_W-1:0] V_REQ_LO = Y_W'(V_ACT - 1);
  localparam logic [Y_W-1:0] VS_BEG   = Y_W'(V_ACT + V_FRONT);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACT + V_FRONT + V_PULSE);

  logic           lock_s, lock_ok;
  state_t         state;
  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic           go, issue, stale;
  logic [Y_W-1:0] req_n;

  lock_qualifier #(.LOCK_N(LOCK_N)) u_lockq (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .lock_s   (lock_s),
    .lock_ok  (lock_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_LOCK;
      h     <= '0;
      v     <= '0;
    end else if (state == WAIT_LOCK) begin
      h <= '0;
      v <= '0;
      if (lock_ok) state <= RUN;
    end else if (!lock_s) begin
      state <= WAIT_LOCK;
      h     <= '0;
      v     <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Losing lock while running blanks the outputs on the same edge the FSM leaves RUN.
  assign go    = (state == RUN) && lock_s;
  assign issue = (h == H_ACT_X) && ((v < V_REQ_LO) || (v == V_LAST));
  assign req_n = (v == V_LAST) ? '0 : v + 1'b1;
  assign stale = (h == '0) && (v < V_ACT_Y) && line_req;

  always_ff @(posedge clk) begin
    if (rst || !go) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_req_y  <= '0;
      running     <= 1'b0;
      if (rst) underrun <= 1'b0;
    end else begin
      running     <= 1'b1;
      de          <= (h < H_ACT_X) && (v < V_ACT_Y);
      hsync       <= (h >= HS_BEG) && (h < HS_END);
      vsync       <= (v >= VS_BEG) && (v < VS_END);
      x           <= h;
      y           <= v;
      frame_start <= (h == '0) && (v == '0);
      if (issue) begin
        line_req   <= 1'b1;
        line_req_y <= req_n;
      end else if (stale) begin
        line_req <= 1'b0;
        underrun <= 1'b1;
      end else if (line_req && line_ack) begin
        line_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster (25x10, lock 16)
// so whole frames fit in a short run.
module tb_video_timing_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        pll_lock;
  logic        hsync, vsync, de, frame_start, line_req, underrun, running;
  logic [10:0] x;
  logic [9:0]  y, line_req_y;
  logic        line_ack;
  logic        ack_man, ack_tie;
  logic [9:0]  skip_y;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign line_ack = ack_man | (ack_tie & line_req & (line_req_y != skip_y));

  video_timing_gen #(
    .H_ACT(16), .H_FRONT(2), .H_PULSE(3), .H_BACK(4),
    .V_ACT(6),  .V_FRONT(1), .V_PULSE(2), .V_BACK(1),
    .LOCK_N(16)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_req(line_req), .line_req_y(line_req_y),
    .line_ack(line_ack), .underrun(underrun), .running(running)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xy(input int tx, input int ty);
    int n = 0;
    while (!(x == 11'(tx) && y == 10'(ty)) && n < 400) begin
      tick();
      n++;
    end
    chk("wait_xy", {31'd0, n < 400}, 32'd1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!line_req && n < 400) begin
      tick();
      n++;
    end
    chk("wait_req", {31'd0, n < 400}, 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {25'd0, hsync, vsync, de, frame_start, line_req, running}, 32'd0);
    chk({tag, "_xy"}, {11'd0, x, y}, 32'd0);
    chk({tag, "_ry"}, {22'd0, line_req_y}, 32'd0);
  endtask

  initial begin
    int de_c, hs_c, vs_c, fs_c, rq_c, hs_x, vs_y, rq_lx, rq_ly;
    int rq [8];
    rst = 1'b1; pll_lock = 1'b0; ack_man = 1'b0; ack_tie = 1'b1; skip_y = 10'h3ff;
    repeat (3) tick();
    chk_idle("reset");
    chk("reset_underrun", {31'd0, underrun}, 32'd0);

    // Glitched lock: counting restarts at the re-rise.
    rst = 1'b0;
    pll_lock = 1'b1;
    repeat (12) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (18) tick();
    chk("lock_early", {31'd0, running}, 32'd0);
    tick();
    chk("lock_run", {31'd0, running}, 32'd1);
    chk("lock_fs", {31'd0, frame_start}, 32'd1);
    chk("lock_de", {31'd0, de}, 32'd1);
    chk("lock_xy", {11'd0, x, y}, 32'd0);

    // One full frame with ack tied to req.
    de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0; rq_c = 0; hs_x = -1; vs_y = -1;
    rq_lx = -1; rq_ly = -1;
    for (int i = 0; i < 250; i++) begin
      de_c += int'(de); hs_c += int'(hsync); vs_c += int'(vsync); fs_c += int'(frame_start);
      if (hsync && hs_x < 0) hs_x = int'(x);
      if (vsync && vs_y < 0) vs_y = int'(y);
      if (line_req) begin
        if (rq_c < 8) rq[rq_c] = int'(line_req_y);
        rq_c++;
        rq_lx = int'(x); rq_ly = int'(y);
      end
      tick();
    end
    chk("frame_de", de_c, 96);
    chk("frame_hs", hs_c, 30);
    chk("frame_vs", vs_c, 50);
    chk("frame_fs", fs_c, 1);
    chk("hs_first_x", hs_x, 18);
    chk("vs_first_y", vs_y, 7);
    chk("req_count", rq_c, 6);
    for (int i = 0; i < 5; i++) chk($sformatf("req_y%0d", i), rq[i], i + 1);
    chk("req_y_wrap", rq[5], 0);
    chk("req_wrap_x", rq_lx, 16);
    chk("req_wrap_y", rq_ly, 9);
    chk("fs_period", {31'd0, frame_start}, 32'd1);
    chk("no_underrun", {31'd0, underrun}, 32'd0);

    // Delayed ack: request holds until acked, clears the cycle after.
    ack_tie = 1'b0;
    wait_req();
    chk("req1_pos", {11'd0, x, y}, {11'd0, 11'd16, 10'd0});
    chk("req1_y", {22'd0, line_req_y}, 32'd1);
    repeat (4) tick();
    chk("req1_hold", {21'd0, line_req, line_req_y}, {21'd0, 1'b1, 10'd1});
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("req1_clear", {31'd0, line_req}, 32'd0);

    // Underrun: request for line 3 is never acked.
    ack_tie = 1'b1;
    skip_y = 10'd3;
    wait_xy(24, 2);
    chk("pre_under", {20'd0, underrun, line_req, line_req_y}, {20'd0, 1'b0, 1'b1, 10'd3});
    tick();
    chk("under_pos", {11'd0, x, y}, {11'd0, 11'd0, 10'd3});
    chk("under_set", {30'd0, underrun, line_req}, {30'd0, 1'b1, 1'b0});
    wait_xy(16, 3);
    chk("req_after", {21'd0, line_req, line_req_y}, {21'd0, 1'b1, 10'd4});
    skip_y = 10'h3ff;

    // Lock loss mid-frame, then relock from (0,0).
    wait_xy(10, 4);
    pll_lock = 1'b0;
    repeat (2) tick();
    chk("loss_still", {31'd0, running}, 32'd1);
    tick();
    chk_idle("loss");
    chk("loss_underrun", {31'd0, underrun}, 32'd1);
    pll_lock = 1'b1;
    repeat (18) tick();
    chk("relock_early", {30'd0, running, frame_start}, 32'd0);
    tick();
    chk("relock_fs", {31'd0, frame_start}, 32'd1);
    chk("relock_xy", {11'd0, x, y}, 32'd0);

    // Reset mid-line.
    repeat (5) tick();
    chk("pre_rst", {11'd0, de, x, y}, {11'd0, 1'b1, 11'd5, 10'd0});
    rst = 1'b1;
    tick();
    chk_idle("rst");
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst", {31'd0, running}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates 1280×720@60 video timing (hsync, vsync, data-enable, pixel coordinates) in the 74.25 MHz pixel-clock domain derived from the TMDS PLL output. Holds output idle until PLL lock has been stable, and issues one line-fetch request per active line to the PSRAM framebuffer reader ahead of that line. It feeds the TMDS encoder/serializer and paces the framebuffer reader.

## Interface
- `H_ACTIVE` = 1280; `H_FP` = 110; `H_SYNC` = 40; `H_BP` = 220. H_TOTAL = 1650.
- `V_ACTIVE` = 720; `V_FP` = 5; `V_SYNC` = 5; `V_BP` = 20. V_TOTAL = 750.
- `LOCK_STABLE` = 1024: consecutive synchronized lock-high cycles required before timing starts.
- `clk` in 1: pixel clock, 74.25 MHz.
- `rst` in 1: synchronous, active-high.
- `pll_lock` in 1: raw PLL lock, asynchronous to `clk`.
- `hsync` out 1: horizontal sync, active-high.
- `vsync` out 1: vertical sync, active-high.
- `de` out 1: active-video enable.
- `x` out 11: horizontal counter.
- `y` out 10: vertical counter.
- `frame_start` out 1: one-cycle pulse at (0,0).
- `line_req` out 1: fetch request for line `line_req_y`.
- `line_req_y` out 10: active line to fetch.
- `line_ack` in 1: reader accepted the request.
- `underrun` out 1: sticky flag; a line began without its request acked.
- `running` out 1: high while in the RUN state.

## Operation
- `pll_lock` passes through a 2-flop synchronizer and becomes `lock_s`.
- FSM state WAIT_LOCK (reset state):
  - Lock counter increments while `lock_s` = 1 and clears whenever `lock_s` = 0.
  - When the counter reaches LOCK_STABLE−1 with `lock_s` = 1, go to RUN with h_cnt = 0 and v_cnt = 0.
- FSM state RUN:
  - h_cnt runs 0..H_TOTAL−1 and wraps to 0.
  - On the h wrap, v_cnt runs 0..V_TOTAL−1 and wraps to 0.
  - If `lock_s` = 0, go to WAIT_LOCK the next cycle: counters clear, all outputs return to reset values, `underrun` is kept.
- Decode, from the counters of the previous cycle:
  - de = h < H_ACTIVE && v < V_ACTIVE.
  - hsync = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 1390..1429.
  - vsync = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. 725..729, and spans whole lines.
  - x = h, y = v.
  - frame_start = (h == 0 && v == 0).
- Line requests:
  - At h == H_ACTIVE on line v, issue a request for line n = v+1 if v+1 < V_ACTIVE.
  - At h == H_ACTIVE on line V_TOTAL−1, issue a request for n = 0.
  - Issuing sets `line_req` = 1 and `line_req_y` = n. `line_req_y` is stable while `line_req` = 1.
  - `line_req` clears in the cycle after `line_ack` = 1 is sampled with `line_req` = 1. `line_ack` while `line_req` = 0 is ignored.
- Underrun:
  - If h == 0 on an active line while `line_req` is still 1, set `underrun`. Only `rst` clears it.
  - The stale request is dropped in that same cycle: `line_req` goes to 0.
  - A new request is issued normally at the next h == H_ACTIVE.
- Simultaneous ack and issue cannot occur, because requests are 1650 cycles apart and a stale request is dropped at h == 0. If they do coincide, issuing has priority.

## Timing
- Reset values: all outputs 0, `line_req_y` = 0, FSM in WAIT_LOCK, lock counter 0.
- Lock to start latency: 2 synchronizer cycles + LOCK_STABLE cycles, then one more cycle until the first registered outputs. `frame_start` and the first `de` appear LOCK_STABLE+3 cycles after `pll_lock` rises.
- All outputs are registered. The output at cycle t reflects the counters at t−1.
- Loss of lock: `running` and `de` drop 3 cycles after `pll_lock` falls (2 sync + 1 FSM).
- `rst` mid-frame: all outputs reach reset values on the next edge.
- Per frame: 1650×750 = 1,237,500 clocks, 720 requests.

## Structure
- Shared package `video_timing_pkg`:
  - 720p constants: H/V active, porch and sync values; H_TOTAL and V_TOTAL.
  - Counter widths: X_W = 11, Y_W = 10.
  - FSM state enum {WAIT_LOCK, RUN}.
- One sub-module, `lock_qualifier`: synchronizer plus stable-lock counter; outputs `lock_ok`.
- Counters, decode and the request logic live in `video_timing_gen`.

## Test plan
- Lock bring-up: `pll_lock` rises at cycle 10 → `running`=1 and `frame_start` pulse at cycle 10+LOCK_STABLE+3; `x`=0, `y`=0, `de`=1 in that cycle.
- Lock glitch: lock high for 500 cycles, low for 1, then high → counter restarts; RUN is entered only after a further 1024 stable cycles.
- Frame geometry, with `line_ack` tied to `line_req`:
  - per line: 1280 `de` cycles; hsync high for 40 cycles starting at x=1390;
  - per frame: 720 lines with `de`; vsync high for lines 725..729 = 8250 cycles;
  - `frame_start` period 1,237,500; `underrun` stays 0.
- Requests: `line_req_y` sequence is 1..719, then 0 issued at line 749, x=1280; `line_req` holds until ack; ack with 100-cycle delay → request clears the cycle after ack.
- Underrun: never ack the request for line 5 → at (0,5) `underrun`=1 and `line_req`=0; the request for line 6 is issued at (1280,5).
- Lock loss mid-frame at (600,300) → 3 cycles later all outputs are 0 and `underrun` is unchanged; relock restarts at (0,0). `rst` pulse mid-line → all outputs 0 next cycle.
